// File: rtl/dff_pipe_if.sv
// dff_pipe bundle: upstream word/qualifier in,
// last-stage word, valid and occupancy out.
interface dff_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
);
  localparam int OW = $clog2(STAGES + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic [OW-1:0]    occupancy;

  modport master (
    output en, flush, in_valid, d,
    input  q, out_valid, occupancy
  );

  modport slave (
    input  en, flush, in_valid, d,
    output q, out_valid, occupancy
  );
endinterface

// File: rtl/dff_pipe.sv
// Enabled, flushable register pipe with per-stage
// valid bits and a registered occupancy count.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic       clk,
  input logic       reset,
  dff_pipe_if.slave bus
);
  localparam int OW = $clog2(STAGES + 1);

  logic [WIDTH-1:0] data [STAGES];
  logic [STAGES-1:0] vld;
  logic [OW-1:0]     occ;

  // Modular add/sub keeps the count exact even
  // when occ+1 would not fit in OW bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        data[i] <= RESET_VAL;
      vld <= '0;
      occ <= '0;
    end else if (bus.flush) begin
      vld <= '0;
      occ <= '0;
    end else if (bus.en) begin
      data[0] <= bus.d;
      vld[0]  <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
      occ <= occ + OW'(bus.in_valid)
                 - OW'(vld[STAGES-1]);
    end
  end

  assign bus.q         = data[STAGES-1];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_dff_pipe.sv
// Directed scoreboard bench for dff_pipe,
// STAGES=4 and STAGES=1 instances.
module tb_dff_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(8), .STAGES(4)) b4 ();
  dff_pipe_if #(.WIDTH(8), .STAGES(1)) b1 ();

  dff_pipe #(
    .WIDTH(8), .STAGES(4), .RESET_VAL(8'hA5)
  ) u4 (
    .clk(clk), .reset(reset), .bus(b4)
  );

  dff_pipe #(
    .WIDTH(8), .STAGES(1), .RESET_VAL(8'hA5)
  ) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  typedef struct {
    logic       sel;
    logic       ov;
    logic [7:0] q;
    logic [2:0] occ;
    int         id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;
  int nstep  = 0;

  task automatic chk(input string n, input int id,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h want %0h",
               n, id, act, exp);
    end
  endtask

  // Monitor: compare the response to the edge just taken.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel) begin
        chk("ov1", e.id, {7'd0, b1.out_valid}, {7'd0, e.ov});
        chk("q1", e.id, b1.q, e.q);
        chk("occ1", e.id, {7'd0, b1.occupancy}, {5'd0, e.occ});
      end else begin
        chk("ov4", e.id, {7'd0, b4.out_valid}, {7'd0, e.ov});
        chk("q4", e.id, b4.q, e.q);
        chk("occ4", e.id, {5'd0, b4.occupancy}, {5'd0, e.occ});
      end
    end
  end

  task automatic step(input logic s, input logic r,
                      input logic f, input logic e,
                      input logic iv, input logic [7:0] dv,
                      input logic ov, input logic [7:0] eq,
                      input logic [2:0] eo);
    exp_t x;
    @(negedge clk);
    reset = r;
    b4.flush = f; b4.en = e; b4.in_valid = iv; b4.d = dv;
    b1.flush = f; b1.en = e; b1.in_valid = iv; b1.d = dv;
    nstep++;
    x.sel = s; x.ov = ov; x.q = eq; x.occ = eo; x.id = nstep;
    sb.push_back(x);
  endtask

  initial begin
    b4.flush = 0; b4.en = 0; b4.in_valid = 0; b4.d = 0;
    b1.flush = 0; b1.en = 0; b1.in_valid = 0; b1.d = 0;
    // reset edge
    step(0, 1, 0, 0, 0, 8'h00, 0, 8'hA5, 0);
    // stream fill
    step(0, 0, 0, 1, 1, 8'h01, 0, 8'hA5, 1);
    step(0, 0, 0, 1, 1, 8'h02, 0, 8'hA5, 2);
    step(0, 0, 0, 1, 1, 8'h03, 0, 8'hA5, 3);
    step(0, 0, 0, 1, 1, 8'h04, 1, 8'h01, 4);
    // freeze
    step(0, 0, 0, 0, 1, 8'hEE, 1, 8'h01, 4);
    step(0, 0, 0, 0, 1, 8'hEE, 1, 8'h01, 4);
    step(0, 0, 0, 0, 1, 8'hEE, 1, 8'h01, 4);
    // reset pulse without a clock edge
    @(negedge clk);
    reset = 1; #2; reset = 0; #1;
    chk("pulse_q", 0, b4.q, 8'h01);
    chk("pulse_ov", 0, {7'd0, b4.out_valid}, 8'd1);
    chk("pulse_occ", 0, {5'd0, b4.occupancy}, 8'd4);
    // resume
    step(0, 0, 0, 1, 1, 8'h05, 1, 8'h02, 4);
    step(0, 0, 0, 1, 1, 8'h06, 1, 8'h03, 4);
    step(0, 0, 0, 1, 1, 8'h07, 1, 8'h04, 4);
    step(0, 0, 0, 1, 1, 8'h08, 1, 8'h05, 4);
    // alternating valid
    step(0, 0, 0, 1, 1, 8'h10, 1, 8'h06, 4);
    step(0, 0, 0, 1, 0, 8'h11, 1, 8'h07, 3);
    step(0, 0, 0, 1, 1, 8'h12, 1, 8'h08, 3);
    step(0, 0, 0, 1, 0, 8'h13, 1, 8'h10, 2);
    step(0, 0, 0, 1, 1, 8'h14, 0, 8'h11, 2);
    step(0, 0, 0, 1, 0, 8'h15, 1, 8'h12, 2);
    step(0, 0, 0, 1, 1, 8'h16, 0, 8'h13, 2);
    step(0, 0, 0, 1, 0, 8'h17, 1, 8'h14, 2);
    // build occupancy 3, then flush with en
    step(0, 0, 0, 1, 1, 8'h20, 0, 8'h15, 2);
    step(0, 0, 0, 1, 1, 8'h21, 1, 8'h16, 3);
    step(0, 0, 1, 1, 1, 8'hFF, 0, 8'h16, 0);
    step(0, 0, 0, 1, 0, 8'h00, 0, 8'h17, 0);
    step(0, 0, 0, 1, 0, 8'h00, 0, 8'h20, 0);
    step(0, 0, 0, 1, 0, 8'h00, 0, 8'h21, 0);
    step(0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0);
    // reset+flush mid-stream, then refill
    step(0, 0, 0, 1, 1, 8'h31, 0, 8'h00, 1);
    step(0, 0, 0, 1, 1, 8'h32, 0, 8'h00, 2);
    step(0, 1, 1, 1, 1, 8'h33, 0, 8'hA5, 0);
    step(0, 0, 0, 1, 1, 8'h41, 0, 8'hA5, 1);
    step(0, 0, 0, 1, 1, 8'h42, 0, 8'hA5, 2);
    step(0, 0, 0, 1, 1, 8'h43, 0, 8'hA5, 3);
    step(0, 0, 0, 1, 1, 8'h44, 1, 8'h41, 4);
    // single-stage instance
    step(1, 1, 0, 0, 0, 8'h00, 0, 8'hA5, 0);
    step(1, 0, 0, 1, 1, 8'h01, 1, 8'h01, 1);
    step(1, 0, 0, 1, 1, 8'h02, 1, 8'h02, 1);
    step(1, 0, 0, 1, 1, 8'h03, 1, 8'h03, 1);
    step(1, 0, 0, 1, 0, 8'h04, 0, 8'h04, 0);
    step(1, 0, 0, 1, 1, 8'h05, 1, 8'h05, 1);
    step(1, 0, 0, 0, 1, 8'h06, 1, 8'h05, 1);
    step(1, 0, 1, 1, 1, 8'h07, 0, 8'h05, 0);
    step(1, 0, 0, 1, 1, 8'h08, 1, 8'h08, 1);
    // drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning the data bit width per stage (legal values >= 1).
REQ-002 The block SHALL expose parameter STAGES, default 4, meaning the number of register stages, i.e. latency in enabled cycles (legal values >= 1).
REQ-003 The block SHALL expose parameter RESET_VAL, default 0, meaning the WIDTH-bit value loaded into every data stage on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high, sampled only on the rising edge of clk.
REQ-006 The block SHALL have port en, input, 1 bit: advance enable; 1 shifts the pipe one stage, 0 holds all state.
REQ-007 The block SHALL have port flush, input, 1 bit: clears all valid bits synchronously.
REQ-008 The block SHALL have port in_valid, input, 1 bit: qualifier for d.
REQ-009 The block SHALL have port d, input, WIDTH bits: data into stage 0.
REQ-010 The block SHALL have port q, output, WIDTH bits: data from the last stage (stage STAGES-1), registered.
REQ-011 The block SHALL have port out_valid, output, 1 bit: valid bit of the last stage, registered.
REQ-012 The block SHALL have port occupancy, output, $clog2(STAGES+1) bits: count of stages currently holding a valid bit, registered.

Function
REQ-013 Each stage SHALL hold one WIDTH-bit data register and one valid bit; no combinational path from any input to q, out_valid or occupancy.
REQ-014 Priority at each rising edge SHALL be: reset, then flush, then en, then hold.
REQ-015 With reset=0, flush=0, en=1: stage0 data <= d, stage0 valid <= in_valid, and stage i <= stage i-1 (data and valid) for i = 1..STAGES-1.
REQ-016 Stage0 data SHALL load d even when in_valid=0; only the valid bit marks the data as meaningful.
REQ-017 With reset=0, flush=0, en=0: all data, valid and occupancy SHALL hold; in_valid and d are ignored.
REQ-018 With reset=0, flush=1: all valid bits SHALL clear and occupancy SHALL become 0; data registers hold; en, in_valid and d are ignored that cycle.
REQ-019 Latency: a word presented with in_valid=1 on an enabled edge SHALL appear on q with out_valid=1 after exactly STAGES enabled edges, with no flush or reset in between; disabled edges add no latency count.
REQ-020 Occupancy next value on an enabled, unflushed edge SHALL be occupancy + in_valid - out_valid (current values); it never exceeds STAGES and never underflows.
REQ-021 Full pipe (occupancy=STAGES) with en=1: the last-stage word is dropped from the pipe (consumed by downstream) as the new word enters; there is no backpressure output.
REQ-022 STAGES=1 SHALL behave as a single enabled, flushable register with a valid bit and occupancy of width 1.
REQ-023 Simultaneous reset and flush SHALL take the reset result; simultaneous flush and en SHALL take the flush result (incoming word lost).

Reset
REQ-024 On a rising edge with reset=1, every stage data register SHALL load RESET_VAL and every valid bit SHALL clear, regardless of en, flush, in_valid and d.
REQ-025 After that edge: q = RESET_VAL, out_valid = 0, occupancy = 0.
REQ-026 Reset asserted between clock edges SHALL have no effect until the next rising edge of clk (no asynchronous path).
REQ-027 Reset mid-operation SHALL discard all in-flight words; the first post-reset word follows REQ-019 latency from the first enabled edge after reset deasserts.

Verification
REQ-028 WIDTH=8, STAGES=4, RESET_VAL=8'hA5; reset for 1 edge -> q=8'hA5, out_valid=0, occupancy=0; pulse reset between edges with no clock edge -> no change.
REQ-029 en=1 continuously, in_valid=1, d = 8'h01, 02, 03... on successive edges -> q=8'h01 with out_valid=1 after the 4th edge, then one word per edge in order; occupancy ramps 1,2,3,4 and stays at 4.
REQ-030 Pipe full with words 01..04, then en=0 for 3 edges -> q, out_valid and occupancy are frozen at 01/1/4; with en=1 again, streaming resumes at 02.
REQ-031 Alternating in_valid 1,0,1,0 with en=1 -> out_valid pattern 1,0,1,0 delayed 4 edges; occupancy settles to 2.
REQ-032 Pipe with occupancy=3, flush=1 together with en=1, in_valid=1, d=8'hFF -> next edge: occupancy=0, out_valid=0, q data unchanged, 8'hFF never emerges.
REQ-033 reset=1 and flush=1 on the same edge, mid-stream -> q=8'hA5, occupancy=0; repeat REQ-029 with STAGES=1 -> latency 1, occupancy toggles only between 0 and 1.
